// File: rtl/frag_pixel_writer_if.sv
// frag_pixel_writer_if: fragment input stream and framebuffer write port of the pixel writer.
// Signals:
//   in_valid/in_rfd        fragment handshake (fragment taken when both high on a clock edge)
//   fp_x/fp_y/color        half-precision normalized coordinates and pixel data
//   fb_wr_req/fb_wr_ack    framebuffer write handshake, fb_wr_addr/fb_wr_data held while unacked
//   frag_count/idle        completed-write counter and empty-pipeline status
// Modports: slave = pixel writer side, master = fragment source / memory side.
interface frag_pixel_writer_if #(
    parameter int ADDR_W = 19
);
    logic              in_valid;
    logic              in_rfd;
    logic [15:0]       fp_x;
    logic [15:0]       fp_y;
    logic [15:0]       color;
    logic              fb_wr_req;
    logic [ADDR_W-1:0] fb_wr_addr;
    logic [15:0]       fb_wr_data;
    logic              fb_wr_ack;
    logic [15:0]       frag_count;
    logic              idle;
    modport slave (
        input  in_valid, fp_x, fp_y, color, fb_wr_ack,
        output in_rfd, fb_wr_req, fb_wr_addr, fb_wr_data, frag_count, idle
    );
    modport master (
        output in_valid, fp_x, fp_y, color, fb_wr_ack,
        input  in_rfd, fb_wr_req, fb_wr_addr, fb_wr_data, frag_count, idle
    );
endinterface

// File: rtl/frag_pixel_writer.sv
// frag_pixel_writer: converts half-precision fragment coordinates to framebuffer addresses and writes them out.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; discards in-flight and buffered fragments
//   bus  frag_pixel_writer_if.slave: fragment stream in, framebuffer write port out, status
// Pipeline: decode (s1) -> scale/clamp (s2) -> address (s3) -> optional dedup -> FIFO -> write port.
module frag_pixel_writer #(
    parameter int FB_W       = 640,
    parameter int FB_H       = 480,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 8,
    parameter int DEDUP      = 1
) (
    input logic                clk,
    input logic                rst,
    frag_pixel_writer_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);

    // Half float to unsigned Q1.16; negatives read as 0, values >= 2 and inf/NaN saturate to 1.0.
    function automatic logic [16:0] dec(input logic [15:0] h);
        logic [4:0]  e;
        logic [16:0] sig;
        logic [16:0] w;
        e   = (h[14:10] == 5'd0) ? 5'd1 : h[14:10];
        sig = {6'd0, h[14:10] != 5'd0, h[9:0]};
        w   = (e >= 5'd9) ? (sig << (e - 5'd9)) : (sig >> (5'd9 - e));
        return h[15] ? 17'd0 : (h[14:10] > 5'd15) ? 17'h10000 : w;
    endfunction

    // floor(fix * n / 2^16) clamped to the last pixel index.
    function automatic logic [ADDR_W-1:0] scale(input logic [16:0] f, input int n);
        logic [31:0] q;
        q = 32'((64'(f) * 64'(n)) >> 16);
        return (q > 32'(n - 1)) ? ADDR_W'(n - 1) : ADDR_W'(q);
    endfunction

    logic              v1_q, v2_q, v3_q, v1_d, v2_d, v3_d;
    logic [16:0]       fx1_q, fy1_q, fx1_d, fy1_d;
    logic [15:0]       c1_q, c2_q, c3_q, c1_d, c2_d, c3_d;
    logic [ADDR_W-1:0] px2_q, py2_q, px2_d, py2_d;
    logic [ADDR_W-1:0] a3_q, a3_d, h_q, h_d;
    logic              hv_q, hv_d;
    logic [PW-1:0]     wp_q, rp_q, wp_d, rp_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic [15:0]       fc_q, fc_d;
    logic [ADDR_W+15:0] mem_q [FIFO_DEPTH];
    logic              accept, push, pop;
    logic [PW+1:0]     occ;

    // Every fragment in the pipeline is reserved a FIFO slot, so the pipeline never stalls.
    assign occ            = (PW+2)'(cnt_q) + (PW+2)'(v1_q) + (PW+2)'(v2_q) + (PW+2)'(v3_q);
    assign bus.in_rfd     = occ <= (PW+2)'(FIFO_DEPTH - 1);
    assign accept         = bus.in_valid & bus.in_rfd;
    assign push           = v3_q & ~(DEDUP != 0 && hv_q && a3_q == h_q);
    assign bus.fb_wr_req  = cnt_q != '0;
    assign pop            = bus.fb_wr_req & bus.fb_wr_ack;
    // Head is masked when empty so the port reads zero instead of stale storage.
    assign {bus.fb_wr_addr, bus.fb_wr_data} = bus.fb_wr_req ? mem_q[rp_q] : '0;
    assign bus.frag_count = fc_q;
    assign bus.idle       = cnt_q == '0 && !v1_q && !v2_q && !v3_q;

    always_comb begin
        v1_d  = accept;
        fx1_d = dec(bus.fp_x);
        fy1_d = dec(bus.fp_y);
        c1_d  = bus.color;
        v2_d  = v1_q;
        px2_d = scale(fx1_q, FB_W);
        py2_d = scale(fy1_q, FB_H);
        c2_d  = c1_q;
        v3_d  = v2_q;
        a3_d  = ADDR_W'(32'(py2_q) * 32'(FB_W) + 32'(px2_q));
        c3_d  = c2_q;
        h_d   = push ? a3_q : h_q;
        hv_d  = hv_q | push;
        wp_d  = wp_q + PW'(push);
        rp_d  = rp_q + PW'(pop);
        cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        fc_d  = fc_q + 16'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            hv_q  <= 1'b0;
            h_q   <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            fc_q  <= '0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            v3_q  <= v3_d;
            hv_q  <= hv_d;
            h_q   <= h_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            fc_q  <= fc_d;
        end
        fx1_q <= fx1_d;
        fy1_q <= fy1_d;
        c1_q  <= c1_d;
        px2_q <= px2_d;
        py2_q <= py2_d;
        c2_q  <= c2_d;
        a3_q  <= a3_d;
        c3_q  <= c3_d;
        if (push && !rst) mem_q[wp_q] <= {a3_q, c3_q};
    end
endmodule

// File: tb/tb_frag_pixel_writer.sv
// tb_frag_pixel_writer: randomized and directed checks of frag_pixel_writer against a real-arithmetic model.
module tb_frag_pixel_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    frag_pixel_writer_if #(.ADDR_W(19)) fif ();
    frag_pixel_writer #(.FB_W(640), .FB_H(480), .ADDR_W(19), .FIFO_DEPTH(8), .DEDUP(1)) dut (
        .clk(clk), .rst(rst), .bus(fif)
    );
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int accepts = 0;
    int last_a = -1;
    int exp_a[$];
    int obs_a[$];
    logic [15:0] exp_d[$];
    logic [15:0] obs_d[$];

    // Value of the half float times 2^16, negative -> 0, >= 2 or inf/NaN -> 1.0.
    function automatic longint fix_of(logic [15:0] h);
        int e;
        int m;
        real v;
        e = int'(h[14:10]);
        m = int'(h[9:0]);
        if (h[15]) return 0;
        if (e == 31) return 65536;
        v = (e == 0) ? (m / 1024.0) * (2.0 ** (-14.0)) : (1.0 + m / 1024.0) * (2.0 ** real'(e - 15));
        if (v >= 2.0) return 65536;
        return longint'($floor(v * 65536.0));
    endfunction

    function automatic int pix_of(logic [15:0] h, int n);
        longint p;
        p = (fix_of(h) * n) / 65536;
        return (p > n - 1) ? n - 1 : int'(p);
    endfunction

    task automatic model_accept(logic [15:0] x, logic [15:0] y, logic [15:0] c);
        int a;
        a = pix_of(y, 480) * 640 + pix_of(x, 640);
        if (a != last_a) begin
            exp_a.push_back(a);
            exp_d.push_back(c);
        end
        last_a = a;
    endtask

    // One clock: note what the coming edge accepts and writes, then move to the next falling edge.
    task automatic cyc();
        #1;
        if (!rst && fif.in_valid && fif.in_rfd) begin
            model_accept(fif.fp_x, fif.fp_y, fif.color);
            accepts++;
        end
        if (!rst && fif.fb_wr_req && fif.fb_wr_ack) begin
            obs_a.push_back(int'(fif.fb_wr_addr));
            obs_d.push_back(fif.fb_wr_data);
        end
        @(negedge clk);
    endtask

    task automatic clear_q();
        exp_a.delete();
        exp_d.delete();
        obs_a.delete();
        obs_d.delete();
    endtask

    task automatic set_frag(logic v, logic [15:0] x, logic [15:0] y, logic [15:0] c);
        fif.in_valid = v;
        fif.fp_x = x;
        fif.fp_y = y;
        fif.color = c;
    endtask

    task automatic drain(output bit ok);
        int n;
        n = 0;
        fif.in_valid = 1'b0;
        fif.fb_wr_ack = 1'b1;
        while (!fif.idle && n < 200) begin
            cyc();
            n++;
        end
        ok = fif.idle;
    endtask

    function automatic logic [15:0] rand_half();
        int k;
        logic [9:0] m;
        k = $urandom_range(0, 99);
        m = 10'($urandom_range(0, 1023));
        if (k < 60) return {1'b0, 5'($urandom_range(1, 14)), m};
        if (k < 70) return 16'h3C00;
        if (k < 78) return {1'b1, 5'($urandom_range(0, 30)), m};
        if (k < 85) return {1'b0, 5'd31, m};
        if (k < 92) return {1'b0, 5'($urandom_range(15, 30)), m};
        return {1'b0, 5'd0, m};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        set_frag(1'b0, 16'h0, 16'h0, 16'h0);
        fif.fb_wr_ack = 1'b0;
        repeat (3) cyc();
        checks++; if (fif.in_rfd !== 1'b1) begin errors++; $display("FAIL reset_in_rfd got=%0b want=1", fif.in_rfd); end
        checks++; if (fif.fb_wr_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b want=0", fif.fb_wr_req); end
        checks++; if (fif.fb_wr_addr !== 19'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", fif.fb_wr_addr); end
        checks++; if (fif.fb_wr_data !== 16'd0) begin errors++; $display("FAIL reset_data got=%h want=0", fif.fb_wr_data); end
        checks++; if (fif.frag_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", fif.frag_count); end
        checks++; if (fif.idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%0b want=1", fif.idle); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single();
        int lat;
        bit ok;
        clear_q();
        fif.fb_wr_ack = 1'b1;
        set_frag(1'b1, 16'h3800, 16'h3800, 16'hF800);
        cyc();
        fif.in_valid = 1'b0;
        lat = 0;
        while (!fif.fb_wr_req && lat < 10) begin
            cyc();
            lat++;
        end
        checks++; if (lat !== 3) begin errors++; $display("FAIL single_latency got=%0d want=3", lat); end
        drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_drain got=not_idle want=idle"); end
        checks++; if (obs_a.size() !== 1) begin errors++; $display("FAIL single_writes got=%0d want=1", obs_a.size()); end
        if (obs_a.size() > 0) begin
            checks++; if (obs_a[0] !== 153920 || obs_d[0] !== 16'hF800) begin errors++; $display("FAIL single_write got=%0d/%h want=153920/f800", obs_a[0], obs_d[0]); end
            checks++; if (exp_a.size() == 0 || obs_a[0] !== exp_a[0]) begin errors++; $display("FAIL single_model got=%0d want=model", obs_a[0]); end
        end
        checks++; if (fif.frag_count !== 16'd1) begin errors++; $display("FAIL single_count got=%0d want=1", fif.frag_count); end
    endtask

    task automatic test_corners();
        logic [15:0] xs[3] = '{16'h3400, 16'h3C00, 16'hB800};
        logic [15:0] ys[3] = '{16'h3400, 16'h3C00, 16'h7C00};
        int want[3] = '{76960, 307199, 306560};
        bit ok;
        clear_q();
        fif.fb_wr_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_frag(1'b1, xs[i], ys[i], 16'(16'h1000 + i));
            cyc();
        end
        drain(ok);
        checks++; if (!ok || obs_a.size() !== 3) begin errors++; $display("FAIL corners_writes got=%0d want=3", obs_a.size()); end
        for (int i = 0; i < 3 && i < obs_a.size(); i++) begin
            checks++;
            if (obs_a[i] !== want[i] || obs_d[i] !== 16'(16'h1000 + i) || i >= exp_a.size() || obs_a[i] !== exp_a[i]) begin
                errors++; $display("FAIL corners_%0d got=%0d/%h want=%0d/%h", i, obs_a[i], obs_d[i], want[i], 16'(16'h1000 + i));
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] x, y, fc0;
        bit ok;
        clear_q();
        fc0 = fif.frag_count;
        x = 16'h3800;
        y = 16'h3800;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                x = rand_half();
                y = rand_half();
            end
            set_frag($urandom_range(0, 9) < 7, x, y, 16'($urandom));
            fif.fb_wr_ack = $urandom_range(0, 9) < 6;
            cyc();
        end
        drain(ok);
        checks++; if (!ok || obs_a.size() !== exp_a.size()) begin errors++; $display("FAIL random_writes got=%0d want=%0d", obs_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
            checks++;
            if (obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) begin
                errors++; $display("FAIL random_%0d got=%0d/%h want=%0d/%h", i, obs_a[i], obs_d[i], exp_a[i], exp_d[i]);
            end
        end
        checks++; if (fif.frag_count !== 16'(fc0 + exp_a.size())) begin errors++; $display("FAIL random_count got=%0d want=%0d", fif.frag_count, 16'(fc0 + exp_a.size())); end
    endtask

    task automatic test_backpressure();
        int n0, i;
        bit ok;
        clear_q();
        fif.fb_wr_ack = 1'b0;
        n0 = accepts;
        i = 0;
        for (int t = 0; t < 14; t++) begin
            set_frag(1'b1, 16'(16'h3000 + i * 16'h80), 16'h3800, 16'(16'hA000 + i));
            cyc();
            i = accepts - n0;
        end
        checks++; if (accepts - n0 !== 8) begin errors++; $display("FAIL bp_accepted got=%0d want=8", accepts - n0); end
        checks++; if (fif.in_rfd !== 1'b0) begin errors++; $display("FAIL bp_in_rfd got=%0b want=0", fif.in_rfd); end
        for (int t = 0; t < 3; t++) begin
            checks++;
            if (exp_a.size() == 0 || fif.fb_wr_req !== 1'b1 || int'(fif.fb_wr_addr) !== exp_a[0] || fif.fb_wr_data !== exp_d[0]) begin
                errors++; $display("FAIL bp_hold_%0d got=%0b/%0d/%h want=1/head", t, fif.fb_wr_req, fif.fb_wr_addr, fif.fb_wr_data);
            end
            cyc();
        end
        drain(ok);
        checks++; if (!ok || obs_a.size() !== 8 || exp_a.size() !== 8) begin errors++; $display("FAIL bp_writes got=%0d want=8", obs_a.size()); end
        for (int k = 0; k < exp_a.size() && k < obs_a.size(); k++) begin
            checks++;
            if (obs_a[k] !== exp_a[k] || obs_d[k] !== exp_d[k]) begin
                errors++; $display("FAIL bp_%0d got=%0d/%h want=%0d/%h", k, obs_a[k], obs_d[k], exp_a[k], exp_d[k]);
            end
        end
        checks++; if (fif.in_rfd !== 1'b1) begin errors++; $display("FAIL bp_rfd_back got=%0b want=1", fif.in_rfd); end
    endtask

    task automatic test_dedup();
        bit ok;
        clear_q();
        fif.fb_wr_ack = 1'b1;
        set_frag(1'b1, 16'h3800, 16'h3800, 16'h0F0F);
        repeat (3) cyc();
        set_frag(1'b1, 16'h3400, 16'h3400, 16'h00FF);
        cyc();
        drain(ok);
        checks++; if (!ok || obs_a.size() !== 2) begin errors++; $display("FAIL dedup_writes got=%0d want=2", obs_a.size()); end
        if (obs_a.size() >= 2) begin
            checks++; if (obs_a[0] !== 153920 || obs_a[1] !== 76960) begin errors++; $display("FAIL dedup_addr got=%0d,%0d want=153920,76960", obs_a[0], obs_a[1]); end
            checks++; if (obs_d[0] !== 16'h0F0F || obs_d[1] !== 16'h00FF) begin errors++; $display("FAIL dedup_data got=%h,%h want=0f0f,00ff", obs_d[0], obs_d[1]); end
        end
    endtask

    task automatic test_ack_toggle();
        int n0, t;
        logic [15:0] fc0;
        clear_q();
        fc0 = fif.frag_count;
        n0 = accepts;
        t = 0;
        while (!(accepts - n0 == 5 && fif.idle) && t < 80) begin
            fif.fb_wr_ack = t[0] == 1'b0;
            set_frag(accepts - n0 < 5, 16'(16'h3100 + (accepts - n0) * 16'h40), 16'h3A00, 16'(16'h5500 + accepts - n0));
            cyc();
            t++;
        end
        checks++; if (fif.idle !== 1'b1) begin errors++; $display("FAIL toggle_idle got=%0b want=1", fif.idle); end
        checks++; if (fif.frag_count !== 16'(fc0 + 5)) begin errors++; $display("FAIL toggle_count got=%0d want=%0d", fif.frag_count, 16'(fc0 + 5)); end
        checks++; if (obs_a.size() !== 5 || exp_a.size() !== 5) begin errors++; $display("FAIL toggle_writes got=%0d want=5", obs_a.size()); end
        for (int k = 0; k < exp_a.size() && k < obs_a.size(); k++) begin
            checks++;
            if (obs_a[k] !== exp_a[k] || obs_d[k] !== exp_d[k]) begin
                errors++; $display("FAIL toggle_%0d got=%0d/%h want=%0d/%h", k, obs_a[k], obs_d[k], exp_a[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] xs[5] = '{16'h3400, 16'h3C00, 16'h3800, 16'h3000, 16'h3500};
        bit ok;
        clear_q();
        fif.fb_wr_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_frag(1'b1, xs[i], 16'h3800, 16'(i));
            cyc();
        end
        fif.in_valid = 1'b0;
        cyc();
        checks++; if (fif.fb_wr_req !== 1'b1 || fif.idle !== 1'b0) begin errors++; $display("FAIL mid_busy got=%0b/%0b want=1/0", fif.fb_wr_req, fif.idle); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (fif.fb_wr_req !== 1'b0) begin errors++; $display("FAIL mid_req got=%0b want=0", fif.fb_wr_req); end
        checks++; if (fif.idle !== 1'b1) begin errors++; $display("FAIL mid_idle got=%0b want=1", fif.idle); end
        checks++; if (fif.frag_count !== 16'd0) begin errors++; $display("FAIL mid_count got=%0d want=0", fif.frag_count); end
        clear_q();
        last_a = -1;
        fif.fb_wr_ack = 1'b1;
        set_frag(1'b1, 16'h3800, 16'h3800, 16'h1234);
        cyc();
        drain(ok);
        checks++; if (!ok || obs_a.size() !== 1) begin errors++; $display("FAIL mid_after_writes got=%0d want=1", obs_a.size()); end
        if (obs_a.size() > 0) begin
            checks++; if (obs_a[0] !== 153920 || obs_d[0] !== 16'h1234) begin errors++; $display("FAIL mid_after got=%0d/%h want=153920/1234", obs_a[0], obs_d[0]); end
        end
        checks++; if (fif.frag_count !== 16'd1) begin errors++; $display("FAIL mid_after_count got=%0d want=1", fif.frag_count); end
    endtask

    initial begin
        set_frag(1'b0, 16'h0, 16'h0, 16'h0);
        fif.fb_wr_ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_corners();
        test_random();
        test_backpressure();
        test_dedup();
        test_ack_toggle();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frag_pixel_writer.md
Name: frag_pixel_writer

Overview:
- Downstream end of the fragment-iterator stream.
- Accepts half-precision normalized fragment coordinates on a valid/ready-for-data handshake and converts them to integer pixel indices.
- Forms a linear framebuffer address, optionally drops back-to-back duplicates, and buffers writes in a FIFO.
- Drains the FIFO to the framebuffer write port on a req/ack handshake. Sits between the triangle rasterizer's fragment iterator and the framebuffer memory controller.

Parameters:
- FB_W, 640, framebuffer width in pixels.
- FB_H, 480, framebuffer height in pixels.
- ADDR_W, 19, framebuffer address width; must satisfy FB_W*FB_H <= 2^ADDR_W.
- FIFO_DEPTH, 8, write FIFO entries (power of two, >= 4).
- DEDUP, 1, 1 = drop a fragment whose address equals the previously accepted fragment's address.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fragment present; driven by iterator rdy.
- in_rfd  out  1  ready for data; drives iterator ds_rfd.
- fp_x  in  16  IEEE half-precision x, nominal range [0,1].
- fp_y  in  16  IEEE half-precision y, nominal range [0,1].
- color  in  16  pixel data, sampled with the fragment.
- fb_wr_req  out  1  write request.
- fb_wr_addr  out  ADDR_W  write address.
- fb_wr_data  out  16  write data.
- fb_wr_ack  in  1  write accepted.
- frag_count  out  16  count of writes completed (wraps).
- idle  out  1  pipeline and FIFO empty.

Behaviour:
- Reset values:
  - in_rfd=1, fb_wr_req=0, fb_wr_addr=0, fb_wr_data=0, frag_count=0, idle=1.
  - FIFO emptied, pipeline valids cleared, dedup history invalidated.
- Reset mid-operation discards all in-flight and buffered fragments. fb_wr_req is 0 in the cycle after rst is sampled.
- Accept: a fragment is taken on any edge where in_valid & in_rfd.
- Flow control: in_rfd = (fifo_count + number of valid pipeline stages) <= FIFO_DEPTH-1, combinational. The FIFO therefore never overflows, and no stall propagates into the pipeline.
- Stage 1, decode, per coordinate:
  - s = sign, e = exponent[14:10], m = mantissa[9:0].
  - sig = {e!=0, m}; treat e==0 as e=1.
  - Q1.16 value fix = sig << (e-9) when e>=9, else sig >> (9-e). Width 17 bits, saturating.
  - e>15 or e==31 (inf/NaN) with s=0: saturate to 0x10000.
  - s=1 (any negative, including -0): force fix=0.
- Stage 2, scale and clamp:
  - px = (fix_x*FB_W)>>16, py = (fix_y*FB_H)>>16, floor.
  - Clamp px to FB_W-1 and py to FB_H-1. For example, 1.0 maps to the last column/row.
- Stage 3, address: addr = py*FB_W + px.
  - DEDUP=1: if addr equals the last accepted stage-3 address and history is valid, discard the entry. Otherwise push {addr, color} into the FIFO and update history.
  - History persists across idle gaps; it is invalidated only by rst.
- Latency: a fragment accepted at edge N is pushed at edge N+3. fb_wr_req is high from cycle N+3 when the FIFO was empty.
- Write port:
  - fb_wr_req = FIFO not empty; fb_wr_addr/fb_wr_data = FIFO head.
  - Outputs stay stable while req & ~ack.
  - Pop and frag_count+1 on each edge with req & ack.
  - Simultaneous push and pop in the same cycle is legal and count-neutral.
  - Push into an empty FIFO with ack already high: that entry is popped no earlier than the cycle after the push (no fall-through).
- idle = FIFO empty & no valid pipeline stage.
- Ordering: writes are issued strictly in acceptance order.

Test Plan:
- Reset, then fp_x=fp_y=0x3800 (0.5), color=0xF800, ack tied 1 -> one write: addr=153920 (240*640+320), data=0xF800, req at accept+3, frag_count=1.
- fp_x=0x3400, fp_y=0x3400 (0.25) -> addr=120*640+160=76960. fp_x=0x3C00, fp_y=0x3C00 (1.0) -> clamped addr=307199. fp_x=0xB800 (-0.5), fp_y=0x7C00 (+inf) -> px=0, py=479, addr=306560.
- ack held 0, in_valid high with 10 distinct fragments -> exactly 8 accepted, then in_rfd=0. Release ack -> 8 writes in acceptance order, each stable while unacked, and in_rfd reasserts.
- DEDUP=1: the same 0x3800/0x3800 fragment presented 3 consecutive cycles, then 0x3400/0x3400 -> exactly 2 writes (153920, 76960).
- ack toggles 1,0,1,0 during a 5-fragment stream -> no loss or duplication, frag_count=5, idle=1 after the last ack.
- rst asserted while FIFO holds 3 entries and 2 are in the pipeline -> next cycle fb_wr_req=0, idle=1, frag_count=0. A following 0x3800 fragment is written (dedup history cleared).
